line_sequencer: RTL and testbench
=================================

Name: line_sequencer

Overview:
Game-level controller for the moving horizontal-line obstacles of Wild Cube. It drives the per-line datapath controls: counter load, motion-FSM start, motion enable (the datapath's `stop` input) and the shared `flash` blink. It sequences reload, staggered release of each line, collision freeze/blink, lives and game over. All timing is counted in frames. It sits between top-level game logic (start button, collision detect) and the N line datapath instances.

Parameters:
N_LINES, 4, number of line instances controlled (1..8)
STAGGER, 30, frames between release of consecutive lines (>=1)
FLASH_HALF, 8, frames per flash half-period (>=1)
FLASH_CYCLES, 4, full on/off blink cycles per collision (>=1)
LIVES, 3, lives at game start (1..3)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame  in  1  one-clk pulse per video frame, clk domain
go  in  1  start/restart request (level)
collision  in  1  cube/line hit, may be a one-clk pulse at any time
load_counter  out  N_LINES  per-line counter load
start_machine  out  N_LINES  per-line motion-FSM start pulse (one frame wide)
move_en  out  N_LINES  per-line motion enable, wired to datapath `stop` (1 = move, solid)
flash  out  1  shared blink, shown when move_en=0
lives  out  2  remaining lives
game_over  out  1  high in OVER
busy  out  1  high in LOAD/ARM/RUN/FLASH

Behaviour:
- Interface: one clock `clk`. Reset `reset` is synchronous and active-high.
- Reset behaviour:
  - Next clk edge gives state=IDLE, load_counter=0, start_machine=0, move_en=0, flash=1, lives=LIVES, game_over=0, busy=0.
  - All counters and hit_pending are cleared.
  - Reset mid-operation has the same effect, and overrides frame, go and collision on that edge.
- Frame qualification: every state transition and counter update happens only on edges where frame=1, except hit_pending latching and reset.
- hit_pending:
  - Set on any clk edge with collision=1 while state is ARM or RUN.
  - Cleared on entry to FLASH and in LOAD.
  - Collision in any other state is ignored.
  - Transition condition is hit = collision | hit_pending, so a collision coincident with frame is taken on that same edge.
- States:
  - IDLE: move_en=0, flash=1. On frame & go go to LOAD.
  - LOAD:
    - load_counter = all ones for the whole state (entry edge to next frame edge), start_machine=0, move_en=0.
    - On frame, release line 0: move_en[0]<=1, start_machine[0]<=1, stagger_cnt<=0, k<=0.
    - Next state is ARM, or RUN if N_LINES=1.
    - load_counter<=0 on exit.
  - ARM:
    - On each frame, any start_machine bit still high is cleared (pulse is exactly one frame period).
    - If hit, go to FLASH. Otherwise stagger_cnt increments.
    - At stagger_cnt=STAGGER-1: k<=k+1, set move_en[k+1] and start_machine[k+1], stagger_cnt<=0.
    - If k+1=N_LINES-1, go to RUN on the same edge.
    - Lines released stay enabled; unreleased bits stay 0.
  - RUN: clear start_machine pulses as in ARM. On frame & hit go to FLASH.
  - FLASH:
    - On entry: move_en<=0, start_machine<=0, flash<=0, fl_cnt<=0, lives<=lives-1 (saturates at 0).
    - Each frame: fl_cnt increments; flash toggles each time fl_cnt reaches a multiple of FLASH_HALF.
    - Total duration is 2*FLASH_HALF*FLASH_CYCLES frames.
    - At the end, flash<=1. Go to OVER if lives=0, else LOAD (automatic reload).
  - OVER: game_over=1, move_en=0, flash=1. On frame & go: lives<=LIVES, go to LOAD.
- busy is a registered decode of state; no output has combinational paths from inputs.
- Widths: stagger_cnt and fl_cnt are wide enough for their maxima; no wrap occurs within a state.
- go is held or re-asserted: if go is high at OVER/IDLE on a frame, restart is immediate.

Test Plan:
1. Reset; go=1; frame every 10 clk, N_LINES=4 -> load_counter=4'hF for 1 frame; then move_en=0001 with start_machine=0001 for 1 frame; 0011 after 30 frames; 0111 after 60; 1111 after 90 with state RUN, busy=1.
2. In RUN, 1-clk collision between frames -> next frame: move_en=0, lives 3->2, flash=0 for 8 frames, 1 for 8, ... 64 frames total; then flash=1, load_counter=4'hF (LOAD).
3. Three successive hits -> after the third flash sequence: game_over=1, lives=0, move_en=0, busy=0. go on a frame -> LOAD, lives=3, game_over=0.
4. Collision in ARM after 2 lines released -> FLASH with move_en=0; lines 2-3 never receive start_machine; after 64 frames a full reload restarts from line 0.
5. Collision in IDLE, LOAD, FLASH and OVER -> ignored (lives unchanged, no state change). Collision on the same clk as frame in RUN -> FLASH entered on that edge.
6. reset asserted for 1 clk mid-FLASH -> next clk: IDLE, flash=1, lives=3, move_en=0, load_counter=0, start_machine=0; a later stale collision is ignored.

Source files
------------

// File: rtl/line_sequencer.sv
// Game-level sequencer for the Wild Cube moving-line obstacles: reload, staggered
// release, collision freeze/blink, lives and game over. All timing is in frames.
module line_sequencer #(
    parameter int N_LINES      = 4,
    parameter int STAGGER      = 30,
    parameter int FLASH_HALF   = 8,
    parameter int FLASH_CYCLES = 4,
    parameter int LIVES        = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame,
    input  logic               go,
    input  logic               collision,
    output logic [N_LINES-1:0] load_counter,
    output logic [N_LINES-1:0] start_machine,
    output logic [N_LINES-1:0] move_en,
    output logic               flash,
    output logic [1:0]         lives,
    output logic               game_over,
    output logic               busy
);

    localparam int FL_TOTAL = 2 * FLASH_HALF * FLASH_CYCLES;
    localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int HW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int FW = $clog2(FL_TOTAL + 1);
    localparam logic [N_LINES-1:0] ALL = '1;
    localparam logic [N_LINES-1:0] ONE = N_LINES'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_FLASH, S_OVER} state_t;

    state_t             state, state_n;
    logic [SW-1:0]      stg_cnt, stg_cnt_n;
    logic [FW-1:0]      fl_cnt, fl_cnt_n;
    logic [HW-1:0]      half_cnt, half_cnt_n;
    logic [2:0]         k, k_n;
    logic               hit_pending, hit_pending_n;
    logic [N_LINES-1:0] load_n, start_n, move_n;
    logic               flash_n;
    logic [1:0]         lives_n;
    logic               hit, to_flash;

    assign hit = collision | hit_pending;

    always_comb begin
        state_n       = state;
        stg_cnt_n     = stg_cnt;
        fl_cnt_n      = fl_cnt;
        half_cnt_n    = half_cnt;
        k_n           = k;
        hit_pending_n = hit_pending;
        load_n        = load_counter;
        start_n       = start_machine;
        move_n        = move_en;
        flash_n       = flash;
        lives_n       = lives;
        to_flash      = 1'b0;

        case (state)
            S_IDLE: begin
                if (frame && go) begin
                    state_n = S_LOAD;
                    load_n  = ALL;
                end
            end
            S_LOAD: begin
                hit_pending_n = 1'b0;
                if (frame) begin
                    load_n    = '0;
                    move_n    = ONE;
                    start_n   = ONE;
                    stg_cnt_n = '0;
                    k_n       = '0;
                    state_n   = (N_LINES == 1) ? S_RUN : S_ARM;
                end
            end
            S_ARM: begin
                if (collision) hit_pending_n = 1'b1;
                if (frame) begin
                    start_n = '0;
                    if (hit) begin
                        to_flash = 1'b1;
                    end else if (stg_cnt == SW'(STAGGER - 1)) begin
                        k_n       = k + 3'd1;
                        move_n    = move_en | (ONE << k_n);
                        start_n   = ONE << k_n;
                        stg_cnt_n = '0;
                        if (int'(k_n) == N_LINES - 1) state_n = S_RUN;
                    end else begin
                        stg_cnt_n = stg_cnt + SW'(1);
                    end
                end
            end
            S_RUN: begin
                if (collision) hit_pending_n = 1'b1;
                if (frame) begin
                    start_n = '0;
                    if (hit) to_flash = 1'b1;
                end
            end
            S_FLASH: begin
                if (frame) begin
                    if (fl_cnt == FW'(FL_TOTAL - 1)) begin
                        flash_n  = 1'b1;
                        fl_cnt_n = '0;
                        if (lives == 2'd0) begin
                            state_n = S_OVER;
                        end else begin
                            state_n = S_LOAD;
                            load_n  = ALL;
                        end
                    end else begin
                        fl_cnt_n = fl_cnt + FW'(1);
                        // half_cnt tracks fl_cnt modulo FLASH_HALF without a divider
                        if (half_cnt == HW'(FLASH_HALF - 1)) begin
                            half_cnt_n = '0;
                            flash_n    = ~flash;
                        end else begin
                            half_cnt_n = half_cnt + HW'(1);
                        end
                    end
                end
            end
            S_OVER: begin
                if (frame && go) begin
                    lives_n = 2'(LIVES);
                    state_n = S_LOAD;
                    load_n  = ALL;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (to_flash) begin
            state_n       = S_FLASH;
            move_n        = '0;
            start_n       = '0;
            flash_n       = 1'b0;
            fl_cnt_n      = '0;
            half_cnt_n    = '0;
            hit_pending_n = 1'b0;
            lives_n       = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            stg_cnt       <= '0;
            fl_cnt        <= '0;
            half_cnt      <= '0;
            k             <= '0;
            hit_pending   <= 1'b0;
            load_counter  <= '0;
            start_machine <= '0;
            move_en       <= '0;
            flash         <= 1'b1;
            lives         <= 2'(LIVES);
            game_over     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            stg_cnt       <= stg_cnt_n;
            fl_cnt        <= fl_cnt_n;
            half_cnt      <= half_cnt_n;
            k             <= k_n;
            hit_pending   <= hit_pending_n;
            load_counter  <= load_n;
            start_machine <= start_n;
            move_en       <= move_n;
            flash         <= flash_n;
            lives         <= lives_n;
            game_over     <= (state_n == S_OVER);
            busy          <= (state_n == S_LOAD) || (state_n == S_ARM) ||
                             (state_n == S_RUN)  || (state_n == S_FLASH);
        end
    end

endmodule

// File: tb/tb_line_sequencer.sv
// Directed bench for line_sequencer: release stagger, flash sequence, lives,
// game over/restart, ignored collisions and mid-flash reset.
module tb_line_sequencer;

    logic       clk = 1'b0;
    logic       reset, frame, go, collision;
    logic [3:0] load_counter, start_machine, move_en;
    logic       flash, game_over, busy;
    logic [1:0] lives;

    int n_chk = 0;
    int n_err = 0;

    line_sequencer #(.N_LINES(4), .STAGGER(30), .FLASH_HALF(8), .FLASH_CYCLES(4), .LIVES(3)) dut (
        .clk(clk), .reset(reset), .frame(frame), .go(go), .collision(collision),
        .load_counter(load_counter), .start_machine(start_machine), .move_en(move_en),
        .flash(flash), .lives(lives), .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // frame pulses every 10 clk; returns on the negedge right after the frame edge
    task automatic frames(input int n);
        repeat (n) begin
            repeat (9) @(negedge clk);
            frame = 1'b1;
            @(negedge clk);
            frame = 1'b0;
        end
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame = 1'b0; go = 1'b0; collision = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_lives", lives, 3);
        chk("rst_flash", flash, 1);
        chk("rst_move", move_en, 0);
        chk("rst_load", load_counter, 0);
        chk("rst_start", start_machine, 0);
        chk("rst_busy", busy, 0);
        chk("rst_over", game_over, 0);

        // collision in IDLE is ignored
        hit_pulse();
        frames(2);
        chk("idle_busy", busy, 0);
        chk("idle_lives", lives, 3);

        // reload and staggered release
        go = 1'b1;
        frames(1);
        go = 1'b0;
        chk("load_lc", load_counter, 4'hF);
        chk("load_busy", busy, 1);
        chk("load_move", move_en, 0);
        frames(1);
        chk("rel0_move", move_en, 4'h1);
        chk("rel0_sm", start_machine, 4'h1);
        chk("rel0_lc", load_counter, 0);
        frames(1);
        chk("rel0_sm_clr", start_machine, 0);
        frames(28);
        chk("pre_rel1", move_en, 4'h1);
        frames(1);
        chk("rel1_move", move_en, 4'h3);
        chk("rel1_sm", start_machine, 4'h2);
        frames(30);
        chk("rel2_move", move_en, 4'h7);
        chk("rel2_sm", start_machine, 4'h4);
        frames(30);
        chk("rel3_move", move_en, 4'hF);
        chk("rel3_sm", start_machine, 4'h8);
        frames(5);
        chk("run_move", move_en, 4'hF);
        chk("run_sm", start_machine, 0);
        chk("run_busy", busy, 1);

        // hit #1 between frames in RUN
        hit_pulse();
        chk("pend_move", move_en, 4'hF);
        frames(1);
        chk("h1_move", move_en, 0);
        chk("h1_lives", lives, 2);
        chk("h1_flash", flash, 0);
        frames(7);
        chk("h1_f7", flash, 0);
        frames(1);
        chk("h1_f8", flash, 1);
        frames(8);
        chk("h1_f16", flash, 0);
        hit_pulse();  // ignored in FLASH
        frames(47);
        chk("h1_f63", flash, 1);
        chk("h1_f63_lc", load_counter, 0);
        frames(1);
        chk("h1_reload_lc", load_counter, 4'hF);
        chk("h1_reload_flash", flash, 1);
        chk("h1_flash_ign", lives, 2);

        // collision in LOAD is ignored
        hit_pulse();
        frames(1);
        chk("load_ign_move", move_en, 4'h1);
        chk("load_ign_lives", lives, 2);
        frames(30);
        chk("arm2_move", move_en, 4'h3);
        frames(5);

        // hit #2 in ARM with two lines released
        hit_pulse();
        frames(1);
        chk("h2_move", move_en, 0);
        chk("h2_lives", lives, 1);
        chk("h2_sm", start_machine, 0);
        frames(63);
        chk("h2_end_move", move_en, 0);
        chk("h2_end_sm", start_machine, 0);
        frames(1);
        chk("h2_reload", load_counter, 4'hF);
        frames(1);
        chk("h2_rel0_move", move_en, 4'h1);
        chk("h2_rel0_sm", start_machine, 4'h1);
        frames(90);
        chk("h2_run_move", move_en, 4'hF);

        // hit #3 coincident with frame in RUN
        repeat (9) @(negedge clk);
        frame = 1'b1; collision = 1'b1;
        @(negedge clk);
        frame = 1'b0; collision = 1'b0;
        chk("h3_move", move_en, 0);
        chk("h3_lives", lives, 0);
        chk("h3_flash", flash, 0);
        frames(63);
        chk("h3_busy", busy, 1);
        frames(1);
        chk("over_go", game_over, 1);
        chk("over_busy", busy, 0);
        chk("over_lives", lives, 0);
        chk("over_flash", flash, 1);
        chk("over_move", move_en, 0);

        // collision in OVER ignored; then restart
        hit_pulse();
        frames(2);
        chk("over_ign", game_over, 1);
        chk("over_ign_lc", load_counter, 0);
        go = 1'b1;
        frames(1);
        go = 1'b0;
        chk("restart_lc", load_counter, 4'hF);
        chk("restart_lives", lives, 3);
        chk("restart_over", game_over, 0);
        chk("restart_busy", busy, 1);

        // reset mid-FLASH
        frames(1);
        hit_pulse();
        frames(1);
        chk("h4_lives", lives, 2);
        frames(3);
        @(negedge clk);
        reset = 1'b1; collision = 1'b1;
        @(negedge clk);
        reset = 1'b0; collision = 1'b0;
        chk("mrst_flash", flash, 1);
        chk("mrst_lives", lives, 3);
        chk("mrst_move", move_en, 0);
        chk("mrst_lc", load_counter, 0);
        chk("mrst_sm", start_machine, 0);
        chk("mrst_busy", busy, 0);
        hit_pulse();
        frames(3);
        chk("mrst_idle", busy, 0);
        go = 1'b1;
        frames(1);
        go = 1'b0;
        frames(2);
        chk("mrst_arm_move", move_en, 4'h1);
        chk("mrst_arm_lives", lives, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
